arp_frame_rx: RTL and testbench
===============================

Name: arp_frame_rx

Overview:
Receive-side ARP frame parser. Accepts an Ethernet header plus an 8-bit AXI-stream payload in the same format the ARP block emits and the test harness drives. It validates the 28-byte ARP body and presents all decoded fields as one flat, held-until-accepted output word. It sits between a MAC/eth_axis_rx path and a TLM monitor or ARP consumer, and reports frame outcomes as one-cycle status pulses.

Parameters:
FILTER_TPA, 0, 1 = drop frames whose target protocol address does not equal local_ip.
STRICT_OPER, 1, 1 = accept only oper 0x0001/0x0002; 0 = accept any oper.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_eth_hdr_valid  in  1  header valid
s_eth_hdr_ready  out  1  header ready
s_eth_dest_mac  in  48  destination MAC
s_eth_src_mac  in  48  source MAC
s_eth_type  in  16  ethertype
s_eth_payload_axis_tdata  in  8  payload byte
s_eth_payload_axis_tvalid  in  1  payload valid
s_eth_payload_axis_tready  out  1  payload ready
s_eth_payload_axis_tlast  in  1  last payload byte
s_eth_payload_axis_tuser  in  1  bad-frame flag, sampled on the tlast beat
local_ip  in  32  compare value for FILTER_TPA
m_frame_valid  out  1  decoded frame valid
m_frame_ready  in  1  decoded frame ready
m_eth_dest_mac  out  48  captured destination MAC
m_eth_src_mac  out  48  captured source MAC
m_arp_oper  out  16  ARP operation
m_arp_sha  out  48  sender hardware address
m_arp_spa  out  32  sender protocol address
m_arp_tha  out  48  target hardware address
m_arp_tpa  out  32  target protocol address
stat_frame_good  out  1  pulse: frame delivered to output
stat_err_short  out  1  pulse: tlast before byte 28
stat_err_hdr  out  1  pulse: header or field check failed
stat_err_bad_frame  out  1  pulse: tuser set on tlast

Behaviour:
- States: IDLE, PAYLOAD, DROP, OUTPUT. Reset forces IDLE. Reset values: all m_* outputs and stat_* outputs = 0; s_eth_hdr_ready = 1 (IDLE); s_eth_payload_axis_tready = 0.
- IDLE: hdr_ready = 1, tready = 0. On a header handshake, latch dest/src MAC and clear byte counter and error flags. If s_eth_type == 0x0806, go to PAYLOAD; otherwise set the header-error flag and go to DROP.
- PAYLOAD: tready = 1, hdr_ready = 0. Each accepted byte at index n (0..27) shifts into the field registers big-endian, first byte = MSB:
  - 0-1 htype (must be 0x0001); 2-3 ptype (must be 0x0800); 4 hlen (must be 6); 5 plen (must be 4)
  - 6-7 oper; 8-13 sha; 14-17 spa; 18-23 tha; 24-27 tpa
- Byte counter is 5 bits and saturates at 28. Bytes beyond index 27 are padding: accepted and discarded.
- Checks on tlast beat, in priority order:
  1. count+1 < 28 -> stat_err_short.
  2. Else tuser = 1 -> stat_err_bad_frame.
  3. Else any field mismatch, oper not 1 or 2 (STRICT_OPER), or tpa != local_ip (FILTER_TPA) -> stat_err_hdr.
  4. Else go to OUTPUT.
  After any error, return to IDLE. Exactly one stat pulse per frame, asserted the cycle after the tlast handshake.
- DROP: tready = 1; consume bytes until the tlast handshake. Emit stat_err_hdr the next cycle, then go to IDLE. tuser is ignored in DROP.
- OUTPUT: m_frame_valid = 1; hdr_ready = 0, tready = 0.
  - All m_* fields are stable while valid && !ready.
  - stat_frame_good pulses on OUTPUT entry, in the same cycle valid first rises.
  - Latency: valid asserts 1 cycle after the tlast handshake.
  - On valid && ready, go to IDLE; hdr_ready returns 1 on the following cycle. There is no same-cycle bypass.
- m_* fields update only on OUTPUT entry. Rejected frames never disturb previously delivered values.
- Header-valid asserted while not in IDLE is not accepted (backpressure only).
- Reset mid-frame: partial frame discarded, no stat pulse, IDLE next cycle. Payload beats without a preceding header are never accepted; upstream is reset together with this block.
- Decoded frame width 336 bits = 48+48+16 header + 224 ARP. The monitor concatenates {dest, src, 0x0806, 0x0001, 0x0800, 0x06, 0x04, oper, sha, spa, tha, tpa}.

Test Plan:
- Request frame dest ffffffffffff, src 5a5152535455, type 0806, body 0001 0800 06 04 0001 5a5152535455 c0a80164 000000000000 c0a80165, ready=1 -> valid 1 cycle after tlast; oper 0001, sha 5a5152535455, spa c0a80164, tha 0, tpa c0a80165; stat_frame_good once.
- Same frame with 18 zero padding bytes (tlast on byte 46) -> identical output; padding consumed; no error.
- tlast on byte 20 -> stat_err_short, no m_frame_valid; next good frame decodes correctly.
- Type 0800 with 46-byte payload -> all bytes consumed, stat_err_hdr after tlast, no valid. Separately, hlen=5 -> stat_err_hdr.
- FILTER_TPA=1, local_ip c0a80166, request frame above -> stat_err_hdr; local_ip c0a80165 -> delivered.
- m_frame_ready held 0 for 10 cycles with a second header pending -> fields stable, hdr_ready 0 throughout. Ready pulse -> IDLE, second header accepted the cycle after. rst asserted at byte 12 of a frame -> no pulse, outputs 0.

Source files
------------

// File: rtl/arp_frame_rx.sv
// Receive-side ARP parser: takes an Ethernet header and an 8-bit payload stream, validates the
// 28-byte ARP body and presents the decoded fields as one word that is held until it is accepted.
module arp_frame_rx #(
    parameter logic FILTER_TPA  = 1'b0,
    parameter logic STRICT_OPER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_eth_hdr_valid,
    output logic        s_eth_hdr_ready,
    input  logic [47:0] s_eth_dest_mac,
    input  logic [47:0] s_eth_src_mac,
    input  logic [15:0] s_eth_type,
    input  logic [7:0]  s_eth_payload_axis_tdata,
    input  logic        s_eth_payload_axis_tvalid,
    output logic        s_eth_payload_axis_tready,
    input  logic        s_eth_payload_axis_tlast,
    input  logic        s_eth_payload_axis_tuser,
    input  logic [31:0] local_ip,
    output logic        m_frame_valid,
    input  logic        m_frame_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_arp_oper,
    output logic [47:0] m_arp_sha,
    output logic [31:0] m_arp_spa,
    output logic [47:0] m_arp_tha,
    output logic [31:0] m_arp_tpa,
    output logic        stat_frame_good,
    output logic        stat_err_short,
    output logic        stat_err_hdr,
    output logic        stat_err_bad_frame
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_DROP,
        ST_OUTPUT
    } state_t;

    state_t       state;
    logic [4:0]   byte_cnt;
    logic [223:0] body;
    logic [47:0]  hdr_dest;
    logic [47:0]  hdr_src;

    logic         beat;
    logic [4:0]   cnt_next;
    logic [223:0] body_next;
    logic         is_short;
    logic         oper_ok;
    logic         tpa_ok;
    logic         fields_ok;

    assign s_eth_hdr_ready           = (state == ST_IDLE);
    assign s_eth_payload_axis_tready = (state == ST_PAYLOAD) || (state == ST_DROP);
    assign m_frame_valid             = (state == ST_OUTPUT);

    assign beat = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;

    // Checks on the tlast beat must see that beat's byte, so they look at the next-state shift register.
    assign cnt_next  = (byte_cnt == 5'd28) ? byte_cnt : byte_cnt + 5'd1;
    assign body_next = (byte_cnt < 5'd28) ? {body[215:0], s_eth_payload_axis_tdata} : body;
    assign is_short  = (byte_cnt < 5'd27);

    assign oper_ok   = !STRICT_OPER || (body_next[175:160] == 16'h0001) || (body_next[175:160] == 16'h0002);
    assign tpa_ok    = !FILTER_TPA || (body_next[31:0] == local_ip);
    assign fields_ok = (body_next[223:208] == 16'h0001) && (body_next[207:192] == 16'h0800) &&
                       (body_next[191:184] == 8'd6) && (body_next[183:176] == 8'd4) &&
                       oper_ok && tpa_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            byte_cnt           <= '0;
            body               <= '0;
            hdr_dest           <= '0;
            hdr_src            <= '0;
            m_eth_dest_mac     <= '0;
            m_eth_src_mac      <= '0;
            m_arp_oper         <= '0;
            m_arp_sha          <= '0;
            m_arp_spa          <= '0;
            m_arp_tha          <= '0;
            m_arp_tpa          <= '0;
            stat_frame_good    <= 1'b0;
            stat_err_short     <= 1'b0;
            stat_err_hdr       <= 1'b0;
            stat_err_bad_frame <= 1'b0;
        end else begin
            stat_frame_good    <= 1'b0;
            stat_err_short     <= 1'b0;
            stat_err_hdr       <= 1'b0;
            stat_err_bad_frame <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_eth_hdr_valid) begin
                        hdr_dest <= s_eth_dest_mac;
                        hdr_src  <= s_eth_src_mac;
                        byte_cnt <= '0;
                        state    <= (s_eth_type == 16'h0806) ? ST_PAYLOAD : ST_DROP;
                    end
                end
                ST_PAYLOAD: begin
                    if (beat) begin
                        body     <= body_next;
                        byte_cnt <= cnt_next;
                        if (s_eth_payload_axis_tlast) begin
                            state <= ST_IDLE;
                            if (is_short) begin
                                stat_err_short <= 1'b1;
                            end else if (s_eth_payload_axis_tuser) begin
                                stat_err_bad_frame <= 1'b1;
                            end else if (!fields_ok) begin
                                stat_err_hdr <= 1'b1;
                            end else begin
                                // Output fields change only here, so rejected frames leave them intact.
                                m_eth_dest_mac  <= hdr_dest;
                                m_eth_src_mac   <= hdr_src;
                                m_arp_oper      <= body_next[175:160];
                                m_arp_sha       <= body_next[159:112];
                                m_arp_spa       <= body_next[111:80];
                                m_arp_tha       <= body_next[79:32];
                                m_arp_tpa       <= body_next[31:0];
                                stat_frame_good <= 1'b1;
                                state           <= ST_OUTPUT;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (beat && s_eth_payload_axis_tlast) begin
                        stat_err_hdr <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                ST_OUTPUT: begin
                    if (m_frame_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_frame_rx.sv
// Directed bench for arp_frame_rx: drives hand-built ARP frames and compares decoded
// fields and status pulses against expected values computed from the stimulus.
module tb_arp_frame_rx;

    localparam logic [47:0] BCAST = 48'hffffffffffff;
    localparam logic [47:0] SRC   = 48'h5a5152535455;
    localparam logic [31:0] SPA   = 32'hc0a80164;
    localparam logic [31:0] TPA   = 32'hc0a80165;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_eth_hdr_valid;
    logic        s_eth_hdr_ready;
    logic [47:0] s_eth_dest_mac;
    logic [47:0] s_eth_src_mac;
    logic [15:0] s_eth_type;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    logic [31:0] local_ip;
    logic        m_frame_valid;
    logic        m_frame_ready;
    logic [47:0] m_eth_dest_mac;
    logic [47:0] m_eth_src_mac;
    logic [15:0] m_arp_oper;
    logic [47:0] m_arp_sha;
    logic [31:0] m_arp_spa;
    logic [47:0] m_arp_tha;
    logic [31:0] m_arp_tpa;
    logic        stat_frame_good;
    logic        stat_err_short;
    logic        stat_err_hdr;
    logic        stat_err_bad_frame;

    int errors = 0;
    int checks = 0;
    logic [7:0] frame_bytes [0:63];

    always #5 clk = ~clk;

    arp_frame_rx #(.FILTER_TPA(1'b1), .STRICT_OPER(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .s_eth_hdr_valid(s_eth_hdr_valid),
        .s_eth_hdr_ready(s_eth_hdr_ready),
        .s_eth_dest_mac(s_eth_dest_mac),
        .s_eth_src_mac(s_eth_src_mac),
        .s_eth_type(s_eth_type),
        .s_eth_payload_axis_tdata(tdata),
        .s_eth_payload_axis_tvalid(tvalid),
        .s_eth_payload_axis_tready(tready),
        .s_eth_payload_axis_tlast(tlast),
        .s_eth_payload_axis_tuser(tuser),
        .local_ip(local_ip),
        .m_frame_valid(m_frame_valid),
        .m_frame_ready(m_frame_ready),
        .m_eth_dest_mac(m_eth_dest_mac),
        .m_eth_src_mac(m_eth_src_mac),
        .m_arp_oper(m_arp_oper),
        .m_arp_sha(m_arp_sha),
        .m_arp_spa(m_arp_spa),
        .m_arp_tha(m_arp_tha),
        .m_arp_tpa(m_arp_tpa),
        .stat_frame_good(stat_frame_good),
        .stat_err_short(stat_err_short),
        .stat_err_hdr(stat_err_hdr),
        .stat_err_bad_frame(stat_err_bad_frame)
    );

    task automatic check_output(input string tag, input logic [335:0] got, input logic [335:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {valid, good, short, hdr, bad_frame}
    function automatic logic [4:0] status();
        return {m_frame_valid, stat_frame_good, stat_err_short, stat_err_hdr, stat_err_bad_frame};
    endfunction

    function automatic logic [335:0] out_word();
        return {m_eth_dest_mac, m_eth_src_mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                m_arp_oper, m_arp_sha, m_arp_spa, m_arp_tha, m_arp_tpa};
    endfunction

    function automatic logic [335:0] exp_word(input logic [47:0] dest, input logic [47:0] src,
                                              input logic [15:0] oper, input logic [47:0] sha,
                                              input logic [31:0] spa, input logic [47:0] tha,
                                              input logic [31:0] tpa);
        return {dest, src, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, oper, sha, spa, tha, tpa};
    endfunction

    task automatic make_frame(input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                              input logic [47:0] tha, input logic [31:0] tpa);
        logic [223:0] b;
        b = {16'h0001, 16'h0800, 8'h06, 8'h04, oper, sha, spa, tha, tpa};
        for (int i = 0; i < 64; i++) begin
            frame_bytes[i] = (i < 28) ? b[223 - 8*i -: 8] : 8'h00;
        end
    endtask

    // Called on a negedge; returns on the negedge after the header handshake.
    task automatic send_header(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] etype);
        int t;
        s_eth_hdr_valid = 1'b1;
        s_eth_dest_mac  = dest;
        s_eth_src_mac   = src;
        s_eth_type      = etype;
        t = 0;
        while (!s_eth_hdr_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check_output("hdr_ready_wait", 336'd0, 336'd1);
        @(posedge clk);
        @(negedge clk);
        s_eth_hdr_valid = 1'b0;
    endtask

    // Sends bytes 0..n-1, tlast on index last_idx; returns on the negedge after the final handshake.
    task automatic apply_stimulus(input int n, input int last_idx, input logic user);
        int t;
        for (int i = 0; i < n; i++) begin
            tdata  = frame_bytes[i];
            tvalid = 1'b1;
            tlast  = (i == last_idx);
            tuser  = user;
            t = 0;
            while (!tready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) check_output("tready_wait", 336'd0, 336'd1);
            @(posedge clk);
            @(negedge clk);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic good_frame(input string tag, input int n);
        send_header(BCAST, SRC, 16'h0806);
        make_frame(16'h0001, SRC, SPA, 48'h0, TPA);
        apply_stimulus(n, n - 1, 1'b0);
        check_output({tag, "_status"}, 336'(status()), 336'(5'b11000));
        check_output({tag, "_word"}, out_word(), exp_word(BCAST, SRC, 16'h0001, SRC, SPA, 48'h0, TPA));
        @(negedge clk);
        check_output({tag, "_after"}, 336'({status(), s_eth_hdr_ready}), 336'(6'b000001));
    endtask

    task automatic bad_frame(input string tag, input int n, input logic user, input logic [4:0] exp);
        apply_stimulus(n, n - 1, user);
        check_output({tag, "_status"}, 336'(status()), 336'(exp));
        @(negedge clk);
        check_output({tag, "_after"}, 336'({status(), s_eth_hdr_ready}), 336'(6'b000001));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s_eth_hdr_valid = 1'b0;
        s_eth_dest_mac = '0;
        s_eth_src_mac = '0;
        s_eth_type = '0;
        tdata = '0;
        tvalid = 1'b0;
        tlast = 1'b0;
        tuser = 1'b0;
        local_ip = TPA;
        m_frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_ctrl", 336'({s_eth_hdr_ready, tready, status()}), 336'(7'b1000000));
        check_output("reset_fields", 336'({m_eth_dest_mac, m_eth_src_mac, m_arp_oper, m_arp_sha,
                                           m_arp_spa, m_arp_tha, m_arp_tpa}), 336'd0);
        rst = 1'b0;
        @(negedge clk);

        good_frame("request", 28);
        good_frame("padded", 46);

        send_header(BCAST, SRC, 16'h0806);
        make_frame(16'h0001, SRC, SPA, 48'h0, TPA);
        bad_frame("short", 21, 1'b0, 5'b00100);
        check_output("short_keeps_word", out_word(), exp_word(BCAST, SRC, 16'h0001, SRC, SPA, 48'h0, TPA));

        send_header(BCAST, 48'h0a0b0c0d0e0f, 16'h0806);
        make_frame(16'h0002, 48'h0a0b0c0d0e0f, 32'h0a000001, SRC, TPA);
        apply_stimulus(28, 27, 1'b0);
        check_output("reply_status", 336'(status()), 336'(5'b11000));
        check_output("reply_word", out_word(),
                     exp_word(BCAST, 48'h0a0b0c0d0e0f, 16'h0002, 48'h0a0b0c0d0e0f, 32'h0a000001, SRC, TPA));
        @(negedge clk);

        send_header(BCAST, SRC, 16'h0800);
        bad_frame("type_ip", 46, 1'b0, 5'b00010);
        check_output("type_ip_keeps_oper", 336'(m_arp_oper), 336'(16'h0002));

        send_header(BCAST, SRC, 16'h0806);
        make_frame(16'h0001, SRC, SPA, 48'h0, TPA);
        frame_bytes[4] = 8'd5;
        bad_frame("hlen5", 28, 1'b0, 5'b00010);

        send_header(BCAST, SRC, 16'h0806);
        make_frame(16'h0003, SRC, SPA, 48'h0, TPA);
        bad_frame("oper3", 28, 1'b0, 5'b00010);

        send_header(BCAST, SRC, 16'h0806);
        make_frame(16'h0001, SRC, SPA, 48'h0, TPA);
        bad_frame("tuser", 28, 1'b1, 5'b00001);

        send_header(BCAST, SRC, 16'h0806);
        bad_frame("tuser_short", 10, 1'b1, 5'b00100);

        local_ip = 32'hc0a80166;
        send_header(BCAST, SRC, 16'h0806);
        bad_frame("tpa_filter", 28, 1'b0, 5'b00010);
        local_ip = TPA;
        good_frame("tpa_match", 28);

        // Backpressure: hold ready low with a second header waiting.
        m_frame_ready = 1'b0;
        send_header(BCAST, SRC, 16'h0806);
        make_frame(16'h0001, SRC, SPA, 48'h0, TPA);
        apply_stimulus(28, 27, 1'b0);
        s_eth_hdr_valid = 1'b1;
        s_eth_dest_mac  = 48'h020000000001;
        s_eth_src_mac   = 48'h665544332211;
        s_eth_type      = 16'h0806;
        for (int c = 0; c < 10; c++) begin
            check_output("hold_ctrl", 336'({m_frame_valid, s_eth_hdr_ready}), 336'(2'b10));
            check_output("hold_word", out_word(), exp_word(BCAST, SRC, 16'h0001, SRC, SPA, 48'h0, TPA));
            @(negedge clk);
        end
        m_frame_ready = 1'b1;
        @(negedge clk);
        check_output("release_idle", 336'({m_frame_valid, s_eth_hdr_ready}), 336'(2'b01));
        @(negedge clk);
        check_output("second_hdr_taken", 336'({s_eth_hdr_ready, tready}), 336'(2'b01));
        s_eth_hdr_valid = 1'b0;
        apply_stimulus(28, 27, 1'b0);
        check_output("second_status", 336'(status()), 336'(5'b11000));
        check_output("second_word", out_word(),
                     exp_word(48'h020000000001, 48'h665544332211, 16'h0001, SRC, SPA, 48'h0, TPA));
        @(negedge clk);

        // Reset in the middle of a frame.
        send_header(BCAST, SRC, 16'h0806);
        apply_stimulus(12, 99, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_ctrl", 336'({s_eth_hdr_ready, tready, status()}), 336'(7'b1000000));
        check_output("midrst_fields", 336'({m_eth_dest_mac, m_eth_src_mac, m_arp_oper, m_arp_sha,
                                            m_arp_spa, m_arp_tha, m_arp_tpa}), 336'd0);
        rst = 1'b0;
        @(negedge clk);
        good_frame("post_reset", 28);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
